muldiv_unit: RTL and testbench

- Parametrised iterative RV32M/RV64M multiply/divide execution unit for the EX stage of the 5-stage pipeline.
- Accepts one operation at a time through a valid/ready handshake and tags each result with its destination register so the writeback path can route it.
- Exposes busy_o to the hazard detection unit so the pipeline stalls while an operation is in flight.
- Supports pipeline flush, for example on a taken branch.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_step.sv | 34 +++
 rtl/muldiv_unit.sv | 178 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct3 encodings,
// FSM states and the divide-class decode.
package muldiv_pkg;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic logic is_div(input logic [2:0] op);
      return op[2];
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: shift-add multiply or restoring divide.
// Purely combinational; the accumulator is {hi, lo} with lo holding multiplier or dividend bits.
module muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic              i_div,
   input  logic [2*XLEN-1:0] i_acc,
   input  logic [XLEN-1:0]   i_opnd,
   input  logic              i_bit,
   output logic [2*XLEN-1:0] o_acc
);

   logic [XLEN:0]   w_sum;
   logic [XLEN:0]   w_rsh;
   logic            w_ge;
   logic [XLEN-1:0] w_sub;

   always_comb begin
      w_sum = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_bit ? {1'b0, i_opnd} : {(XLEN+1){1'b0}});
      w_rsh = {i_acc[2*XLEN-1:XLEN], i_bit};
      w_ge  = (w_rsh >= {1'b0, i_opnd});
      // Partial remainder is always below the divisor, so the low XLEN bits suffice.
      w_sub = w_rsh[XLEN-1:0] - i_opnd;
      o_acc = {w_sum, i_acc[XLEN-1:1]};
      if (i_div) begin
         if (w_ge) begin
            o_acc = {w_sub, i_acc[XLEN-2:0], 1'b1};
         end else begin
            o_acc = {w_rsh[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M mul/div: XLEN+1 cycles (1 for div-by-zero/overflow), one op in flight.
// Result held in DONE until ready_i; flush_i discards the op, rst_i also clears result and tag.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [2:0]       op_i,
   input  logic [XLEN-1:0]  a_i,
   input  logic [XLEN-1:0]  b_i,
   input  logic [TAG_W-1:0] tag_i,
   input  logic             flush_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [XLEN-1:0]  result_o,
   output logic [TAG_W-1:0] tag_o,
   output logic             busy_o
);

   localparam int CW = $clog2(XLEN);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [2:0]        r_op;
   logic [TAG_W-1:0]  r_tag;
   logic [TAG_W-1:0]  r_tag_out;
   logic [2*XLEN-1:0] r_acc;
   logic [XLEN-1:0]   r_opnd;
   logic              r_neg;
   logic [CW-1:0]     r_cnt;
   logic              r_valid;
   logic [XLEN-1:0]   r_result;

   logic              w_accept;
   logic              w_last;
   logic              w_sgn_a;
   logic              w_sgn_b;
   logic              w_sa;
   logic              w_sb;
   logic [XLEN-1:0]   w_amag;
   logic [XLEN-1:0]   w_bmag;
   logic              w_div0;
   logic              w_ovf;
   logic              w_fast;
   logic [XLEN-1:0]   w_fast_res;
   logic [2*XLEN-1:0] w_step_acc;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_quo;
   logic [XLEN-1:0]   w_rem;
   logic [XLEN-1:0]   w_calc_res;

   assign ready_o  = (r_state == S_IDLE) && !rst_i;
   assign busy_o   = (r_state != S_IDLE);
   assign valid_o  = r_valid;
   assign result_o = r_result;
   assign tag_o    = r_tag_out;

   assign w_accept = valid_i && ready_o && !flush_i;
   assign w_last   = (r_state == S_CALC) && (r_cnt == CW'(XLEN - 1));

   // Operands are reduced to magnitudes; the sign is reapplied after the last iteration.
   assign w_sgn_a  = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
   assign w_sgn_b  = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
   assign w_sa     = w_sgn_a && a_i[XLEN-1];
   assign w_sb     = w_sgn_b && b_i[XLEN-1];
   assign w_amag   = w_sa ? (~a_i + 1'b1) : a_i;
   assign w_bmag   = w_sb ? (~b_i + 1'b1) : b_i;

   assign w_div0     = is_div(op_i) && (b_i == '0);
   assign w_ovf      = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                       (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
   assign w_fast     = w_div0 || w_ovf;
   assign w_fast_res = w_div0 ? (op_i[1] ? a_i : '1) : (op_i[1] ? '0 : a_i);

   muldiv_step #(.XLEN(XLEN)) u_step (
      .i_div  (is_div(r_op)),
      .i_acc  (r_acc),
      .i_opnd (r_opnd),
      .i_bit  (is_div(r_op) ? r_acc[XLEN-1] : r_acc[0]),
      .o_acc  (w_step_acc)
   );

   assign w_prod = r_neg ? (~w_step_acc + 1'b1) : w_step_acc;
   assign w_quo  = r_neg ? (~w_step_acc[XLEN-1:0] + 1'b1) : w_step_acc[XLEN-1:0];
   assign w_rem  = r_neg ? (~w_step_acc[2*XLEN-1:XLEN] + 1'b1) : w_step_acc[2*XLEN-1:XLEN];

   always_comb begin
      w_calc_res = '0;
      case (r_op)
         OP_MUL:                       w_calc_res = w_prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: w_calc_res = w_prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              w_calc_res = w_quo;
         OP_REM, OP_REMU:              w_calc_res = w_rem;
         default:                      w_calc_res = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (flush_i) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_fast ? S_DONE : S_CALC;
            S_CALC:  if (w_last)   w_state_nxt = S_DONE;
            S_DONE:  if (ready_i)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_op      <= '0;
         r_tag     <= '0;
         r_tag_out <= '0;
         r_acc     <= '0;
         r_opnd    <= '0;
         r_neg     <= 1'b0;
         r_cnt     <= '0;
         r_valid   <= 1'b0;
         r_result  <= '0;
      end else if (flush_i) begin
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op  <= op_i;
                  r_tag <= tag_i;
                  r_cnt <= '0;
                  // Remainder takes the dividend's sign; everything else the product/quotient sign.
                  r_neg <= (op_i == OP_REM) ? w_sa : (w_sa ^ w_sb);
                  if (is_div(op_i)) begin
                     r_acc  <= {{XLEN{1'b0}}, w_amag};
                     r_opnd <= w_bmag;
                  end else begin
                     r_acc  <= {{XLEN{1'b0}}, w_bmag};
                     r_opnd <= w_amag;
                  end
                  if (w_fast) begin
                     r_valid   <= 1'b1;
                     r_result  <= w_fast_res;
                     r_tag_out <= tag_i;
                  end
               end
            end
            S_CALC: begin
               r_acc <= w_step_acc;
               r_cnt <= r_cnt + CW'(1);
               if (w_last) begin
                  r_valid   <= 1'b1;
                  r_result  <= w_calc_res;
                  r_tag_out <= r_tag;
               end
            end
            S_DONE: begin
               if (ready_i) r_valid <= 1'b0;
            end
            default: r_valid <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at XLEN=32: vector table through a scoreboard,
// then hand-written backpressure, flush and mid-operation reset sequences.
module tb_muldiv_unit;

   localparam int XLEN  = 32;
   localparam int TAG_W = 5;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             valid_i;
   logic             ready_o;
   logic [2:0]       op_i;
   logic [XLEN-1:0]  a_i;
   logic [XLEN-1:0]  b_i;
   logic [TAG_W-1:0] tag_i;
   logic             flush_i;
   logic             valid_o;
   logic             ready_i;
   logic [XLEN-1:0]  result_o;
   logic [TAG_W-1:0] tag_o;
   logic             busy_o;

   muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .op_i     (op_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .tag_i    (tag_i),
      .flush_i  (flush_i),
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .result_o (result_o),
      .tag_o    (tag_o),
      .busy_o   (busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string            name;
      logic [2:0]       op;
      logic [XLEN-1:0]  a;
      logic [XLEN-1:0]  b;
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  res;
      int               lat;
   } vec_t;

   typedef struct {
      logic [XLEN-1:0]  res;
      logic [TAG_W-1:0] tag;
      int               lat;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[12];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Drives one request (accepted on the next edge) and returns once valid_o is seen or the budget expires.
   task automatic issue(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [TAG_W-1:0] tag, output int lat);
      chk("ready_before_issue", ready_o, 1);
      op_i = op; a_i = a; b_i = b; tag_i = tag; valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      op_i = '0; a_i = '0; b_i = '0; tag_i = '0;
      lat = 1;
      while (!valid_o && lat < 100) begin
         tick();
         lat++;
      end
   endtask

   task automatic compare_out(input string nm, input int lat);
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: scoreboard empty at output", nm);
      end else begin
         e = sb.pop_front();
         chk({nm, "_valid"}, valid_o, 1);
         chk({nm, "_result"}, result_o, e.res);
         chk({nm, "_tag"}, tag_o, e.tag);
         chk({nm, "_latency"}, lat, e.lat);
      end
   endtask

   task automatic run_vec(input vec_t v);
      exp_t e;
      int   lat;
      e.res = v.res; e.tag = v.tag; e.lat = v.lat;
      sb.push_back(e);
      issue(v.op, v.a, v.b, v.tag, lat);
      compare_out(v.name, lat);
      tick();
      chk({v.name, "_valid_drop"}, valid_o, 0);
   endtask

   initial begin
      exp_t e;
      int   lat;
      logic seen;
      logic [XLEN-1:0]  held_res;
      logic [TAG_W-1:0] held_tag;

      vecs[0]  = '{"mul",      3'd0, 32'd7,        32'hFFFFFFFD, 5'd9,  32'hFFFFFFEB, 33};
      vecs[1]  = '{"mulh",     3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'h00000000, 33};
      vecs[2]  = '{"mulhu",    3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 33};
      vecs[3]  = '{"mulhsu",   3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, 33};
      vecs[4]  = '{"div_neg",  3'd4, 32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFD, 33};
      vecs[5]  = '{"rem_neg",  3'd6, 32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFF, 33};
      vecs[6]  = '{"divu",     3'd5, 32'd100,      32'd7,        5'd6,  32'd14,       33};
      vecs[7]  = '{"remu",     3'd7, 32'd100,      32'd7,        5'd7,  32'd2,        33};
      vecs[8]  = '{"divu_z",   3'd5, 32'd5,        32'd0,        5'd8,  32'hFFFFFFFF, 1};
      vecs[9]  = '{"rem_z",    3'd6, 32'd5,        32'd0,        5'd10, 32'd5,        1};
      vecs[10] = '{"div_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1};
      vecs[11] = '{"rem_ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0,        1};

      rst_i = 1'b1; valid_i = 1'b0; op_i = '0; a_i = '0; b_i = '0; tag_i = '0;
      flush_i = 1'b0; ready_i = 1'b1;
      tick();
      tick();
      chk("rst_valid", valid_o, 0);
      chk("rst_result", result_o, 0);
      chk("rst_tag", tag_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_ready", ready_o, 0);
      rst_i = 1'b0;
      #1;
      chk("post_rst_ready", ready_o, 1);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Backpressure: result must hold while the consumer stalls.
      ready_i = 1'b0;
      e.res = 32'd14; e.tag = 5'd3; e.lat = 33;
      sb.push_back(e);
      issue(3'd5, 32'd100, 32'd7, 5'd3, lat);
      compare_out("bp", lat);
      held_res = result_o;
      held_tag = tag_o;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("bp_hold_valid", valid_o, 1);
         chk("bp_hold_result", result_o, held_res);
         chk("bp_hold_tag", tag_o, held_tag);
         chk("bp_hold_ready", ready_o, 0);
      end
      ready_i = 1'b1;
      tick();
      chk("bp_release_valid", valid_o, 0);
      chk("bp_release_ready", ready_o, 1);

      // Flush during CALC iteration 10.
      op_i = 3'd0; a_i = 32'd123; b_i = 32'd456; tag_i = 5'd20; valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      repeat (10) tick();
      chk("flush_busy_before", busy_o, 1);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk("flush_ready", ready_o, 1);
      chk("flush_busy", busy_o, 0);
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (valid_o) seen = 1'b1;
         tick();
      end
      chk("flush_no_valid", seen, 0);
      run_vec('{"divu_after_flush", 3'd5, 32'd9, 32'd3, 5'd13, 32'd3, 33});

      // A request arriving together with flush is dropped.
      op_i = 3'd5; a_i = 32'd9; b_i = 32'd0; tag_i = 5'd14; valid_i = 1'b1; flush_i = 1'b1;
      tick();
      valid_i = 1'b0; flush_i = 1'b0;
      chk("flush_drop_busy", busy_o, 0);
      chk("flush_drop_valid", valid_o, 0);

      // Reset mid-CALC clears outputs, including the previous result.
      op_i = 3'd4; a_i = 32'd1000; b_i = 32'd3; tag_i = 5'd21; valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      repeat (5) tick();
      chk("midrst_busy_before", busy_o, 1);
      rst_i = 1'b1;
      tick();
      chk("midrst_valid", valid_o, 0);
      chk("midrst_result", result_o, 0);
      chk("midrst_tag", tag_o, 0);
      chk("midrst_busy", busy_o, 0);
      chk("midrst_ready", ready_o, 0);
      rst_i = 1'b0;
      #1;
      chk("midrst_ready_after", ready_o, 1);
      tick();
      run_vec('{"remu_after_rst", 3'd7, 32'd100, 32'd7, 5'd15, 32'd2, 33});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
